// File: rtl/apu_pkg.sv
// Shared constants, types and the step decode for the APU master control.
package apu_pkg;

  // Bit positions inside the one-hot register select.
  localparam int SEL_FF24 = 0;
  localparam int SEL_FF25 = 1;
  localparam int SEL_FF26 = 2;

  // Frame-sequencer step number (eight steps).
  typedef logic [2:0] seq_step_t;

  // The three sequencer outputs, fired together for one step.
  typedef struct packed {
    logic length;
    logic sweep;
    logic env;
  } seq_ticks_t;

  // Reset values.
  localparam seq_step_t  STEP_RST      = 3'd0;
  localparam seq_ticks_t TICKS_NONE    = '0;
  localparam logic       POWER_RST     = 1'b0;
  localparam logic       TEST_FAST_RST = 1'b0;
  localparam logic [1:0] CE_CNT_RST    = 2'd0;

  // Which ticks a given step produces: length on even steps,
  // sweep on steps 2 and 6, envelope on step 7.
  function automatic seq_ticks_t step_ticks(input seq_step_t step);
    seq_ticks_t t;
    t.length = ~step[0];
    t.sweep  = (step[1:0] == 2'b10);
    t.env    = (step == 3'd7);
    return t;
  endfunction

endpackage

// File: rtl/apu_frame_seq.sv
// Frame sequencer: picks the tick source (div_src edge or fast test counter),
// advances the 8-step counter and registers the per-step tick pulses.
module apu_frame_seq
  import apu_pkg::*;
#(
  parameter int TEST_DIV = 4
) (
  input  logic       clk_i,
  input  logic       nreset_i,
  input  logic       run_i,        // powered and staying powered this edge
  input  logic       test_fast_i,
  input  logic       div_src_i,
  output seq_step_t  step_o,
  output seq_ticks_t ticks_o
);

  localparam int CW = (TEST_DIV > 1) ? $clog2(TEST_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(TEST_DIV - 1);

  logic          div_q;
  logic          div_qq;
  logic [CW-1:0] div_cnt_q;
  logic [CW-1:0] div_cnt_d;
  seq_step_t     step_q;
  seq_step_t     step_d;
  seq_ticks_t    ticks_q;
  seq_ticks_t    ticks_d;
  logic          div_rise;
  logic          tick;

  // Next-state: pick the tick source, advance step and fire ticks; all held idle when not running.
  always_comb begin
    div_rise  = div_q & ~div_qq;
    tick      = test_fast_i ? (div_cnt_q == DIV_LAST) : div_rise;
    div_cnt_d = div_cnt_q;
    step_d    = step_q;
    ticks_d   = TICKS_NONE;
    if (!run_i) begin
      div_cnt_d = '0;
      step_d    = STEP_RST;
    end else begin
      div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + CW'(1);
      if (tick) begin
        ticks_d = step_ticks(step_q);
        step_d  = step_q + 3'd1;
      end
    end
  end

  // State registers; div_src is sampled through two flops so the edge is seen one cycle late.
  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      div_q     <= 1'b0;
      div_qq    <= 1'b0;
      div_cnt_q <= '0;
      step_q    <= STEP_RST;
      ticks_q   <= TICKS_NONE;
    end else begin
      div_q     <= div_src_i;
      div_qq    <= div_q;
      div_cnt_q <= div_cnt_d;
      step_q    <= step_d;
      ticks_q   <= ticks_d;
    end
  end

  assign step_o  = step_q;
  assign ticks_o = ticks_q;

endmodule

// File: rtl/apu_master_ctrl.sv
// APU master control: volume/VIN (FF24), panning (FF25) and power/status (FF26)
// registers, APU reset generation, 2/1 MHz clock enables and frame sequencer.
//
// Bus access: apu_wr is a single-cycle write strobe qualified by a one-hot
// reg_sel and takes effect at that edge; reads are combinational while cpu_rd
// is high. There is no back-pressure, so no valid/ready pairing applies.
module apu_master_ctrl
  import apu_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_CH   = 4,
  parameter int TEST_DIV = 4
) (
  input  logic                  apuv_4mhz,
  input  logic                  nreset,
  input  logic                  apu_wr,
  input  logic                  cpu_rd,
  input  logic [2:0]            reg_sel,
  input  logic [DATA_W-1:0]     d_in,
  output logic [DATA_W-1:0]     d_out,
  output logic                  d_oe,
  input  logic                  t1_nt2,
  input  logic                  div_src,
  input  logic [NUM_CH-1:0]     ch_active,
  output logic                  apu_reset,
  output logic                  napu_reset,
  output logic                  ce_2mhz,
  output logic                  ce_1mhz,
  output logic                  length_tick,
  output logic                  sweep_tick,
  output logic                  env_tick,
  output logic [2:0]            seq_step,
  output logic [NUM_CH-1:0]     lmixer,
  output logic [NUM_CH-1:0]     rmixer,
  output logic [DATA_W/2-2:0]   lvolume,
  output logic [DATA_W/2-2:0]   rvolume,
  output logic                  vin_l_ena,
  output logic                  vin_r_ena
);

  localparam int HALF  = DATA_W / 2;
  localparam int VOL_W = HALF - 1;

  logic              power_q,     power_d;
  logic              test_fast_q, test_fast_d;
  logic [DATA_W-1:0] ff24_q,      ff24_d;
  logic [NUM_CH-1:0] lmix_q,      lmix_d;
  logic [NUM_CH-1:0] rmix_q,      rmix_d;
  logic [1:0]        ce_cnt_q,    ce_cnt_d;
  logic              ce2_q,       ce2_d;
  logic              ce1_q,       ce1_d;

  logic              wr24, wr25, wr26;
  logic              run;
  logic [DATA_W-1:0] rd24, rd25, rd26;
  seq_step_t         step;
  seq_ticks_t        ticks;

  assign wr24 = apu_wr & reg_sel[SEL_FF24];
  assign wr25 = apu_wr & reg_sel[SEL_FF25];
  assign wr26 = apu_wr & reg_sel[SEL_FF26];

  // Running means powered now and not being switched off at this edge, so a
  // power-off write silences everything on the same edge.
  assign run = power_q & power_d;

  // Register next-state: FF26 write first, then clear or update FF24/FF25 based on the new power state.
  always_comb begin
    power_d     = power_q;
    test_fast_d = test_fast_q;
    ff24_d      = ff24_q;
    lmix_d      = lmix_q;
    rmix_d      = rmix_q;
    if (wr26) begin
      power_d     = d_in[DATA_W-1];
      test_fast_d = d_in[HALF] & t1_nt2;
    end
    if (!power_d) begin
      test_fast_d = 1'b0;
      ff24_d      = '0;
      lmix_d      = '0;
      rmix_d      = '0;
    end else begin
      if (wr24) ff24_d = d_in;
      if (wr25) begin
        lmix_d = d_in[NUM_CH-1:0];
        rmix_d = d_in[HALF+NUM_CH-1:HALF];
      end
    end
  end

  // Clock-enable next-state: counter restarts from 0 at power-on, pulses registered.
  always_comb begin
    ce_cnt_d = run ? ce_cnt_q + 2'd1 : CE_CNT_RST;
    ce2_d    = run & ce_cnt_q[0];
    ce1_d    = run & (ce_cnt_q == 2'd3);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge apuv_4mhz) begin
    if (!nreset) begin
      power_q     <= POWER_RST;
      test_fast_q <= TEST_FAST_RST;
      ff24_q      <= '0;
      lmix_q      <= '0;
      rmix_q      <= '0;
      ce_cnt_q    <= CE_CNT_RST;
      ce2_q       <= 1'b0;
      ce1_q       <= 1'b0;
    end else begin
      power_q     <= power_d;
      test_fast_q <= test_fast_d;
      ff24_q      <= ff24_d;
      lmix_q      <= lmix_d;
      rmix_q      <= rmix_d;
      ce_cnt_q    <= ce_cnt_d;
      ce2_q       <= ce2_d;
      ce1_q       <= ce1_d;
    end
  end

  apu_frame_seq #(
    .TEST_DIV (TEST_DIV)
  ) u_frame_seq (
    .clk_i       (apuv_4mhz),
    .nreset_i    (nreset),
    .run_i       (run),
    .test_fast_i (test_fast_q),
    .div_src_i   (div_src),
    .step_o      (step),
    .ticks_o     (ticks)
  );

  // Read mux: unstored bits read 1; output is zero unless a register is being read.
  always_comb begin
    rd24                      = ff24_q;
    rd25                      = '1;
    rd25[NUM_CH-1:0]          = lmix_q;
    rd25[HALF+NUM_CH-1:HALF]  = rmix_q;
    rd26                      = '1;
    rd26[DATA_W-1]            = power_q;
    rd26[NUM_CH-1:0]          = ch_active;
    d_out                     = '0;
    if (cpu_rd) begin
      if (reg_sel[SEL_FF24]) d_out = d_out | rd24;
      if (reg_sel[SEL_FF25]) d_out = d_out | rd25;
      if (reg_sel[SEL_FF26]) d_out = d_out | rd26;
    end
  end

  assign d_oe        = cpu_rd & (|reg_sel);
  assign apu_reset   = ~power_q;
  assign napu_reset  = power_q;
  assign ce_2mhz     = ce2_q;
  assign ce_1mhz     = ce1_q;
  assign length_tick = ticks.length;
  assign sweep_tick  = ticks.sweep;
  assign env_tick    = ticks.env;
  assign seq_step    = step;
  assign lmixer      = lmix_q;
  assign rmixer      = rmix_q;
  assign lvolume     = ff24_q[VOL_W-1:0];
  assign vin_l_ena   = ff24_q[HALF-1];
  assign rvolume     = ff24_q[DATA_W-2:HALF];
  assign vin_r_ena   = ff24_q[DATA_W-1];

endmodule

// File: tb/tb_apu_master_ctrl.sv
// Directed bench for apu_master_ctrl: registers, power control, frame
// sequencer (div_src and fast test mode), clock enables and reset.
module tb_apu_master_ctrl;

  localparam logic [2:0] S24 = 3'b001;
  localparam logic [2:0] S25 = 3'b010;
  localparam logic [2:0] S26 = 3'b100;

  logic       clk;
  logic       nreset;
  logic       apu_wr;
  logic       cpu_rd;
  logic [2:0] reg_sel;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       d_oe;
  logic       t1_nt2;
  logic       div_src;
  logic [3:0] ch_active;
  logic       apu_reset, napu_reset;
  logic       ce_2mhz, ce_1mhz;
  logic       length_tick, sweep_tick, env_tick;
  logic [2:0] seq_step;
  logic [3:0] lmixer, rmixer;
  logic [2:0] lvolume, rvolume;
  logic       vin_l_ena, vin_r_ena;

  int checks   = 0;
  int failures = 0;
  int len_n, sw_n, env_n;
  logic [7:0] rdata;
  logic [8:0] ce2_v, ce1_v;

  apu_master_ctrl dut (
    .apuv_4mhz   (clk),
    .nreset      (nreset),
    .apu_wr      (apu_wr),
    .cpu_rd      (cpu_rd),
    .reg_sel     (reg_sel),
    .d_in        (d_in),
    .d_out       (d_out),
    .d_oe        (d_oe),
    .t1_nt2      (t1_nt2),
    .div_src     (div_src),
    .ch_active   (ch_active),
    .apu_reset   (apu_reset),
    .napu_reset  (napu_reset),
    .ce_2mhz     (ce_2mhz),
    .ce_1mhz     (ce_1mhz),
    .length_tick (length_tick),
    .sweep_tick  (sweep_tick),
    .env_tick    (env_tick),
    .seq_step    (seq_step),
    .lmixer      (lmixer),
    .rmixer      (rmixer),
    .lvolume     (lvolume),
    .rvolume     (rvolume),
    .vin_l_ena   (vin_l_ena),
    .vin_r_ena   (vin_r_ena)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: all are entered at a negedge and return at a negedge.
  task automatic bus_write(input logic [2:0] sel, input logic [7:0] data);
    apu_wr  = 1'b1;
    reg_sel = sel;
    d_in    = data;
    @(negedge clk);
    apu_wr  = 1'b0;
    reg_sel = 3'b000;
    d_in    = 8'h00;
  endtask

  task automatic bus_read(input logic [2:0] sel, output logic [7:0] data);
    cpu_rd  = 1'b1;
    reg_sel = sel;
    #1;
    data    = d_out;
    check("d_oe_on_read", d_oe, 1);
    cpu_rd  = 1'b0;
    reg_sel = 3'b000;
    #1;
  endtask

  task automatic clear_counts();
    len_n = 0;
    sw_n  = 0;
    env_n = 0;
  endtask

  task automatic sample();
    len_n += int'(length_tick);
    sw_n  += int'(sweep_tick);
    env_n += int'(env_tick);
  endtask

  // One div_src pulse, 3 cycles high then 3 low, sampling ticks every cycle.
  task automatic div_pulse();
    div_src = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) div_src = 1'b0;
      sample();
    end
  endtask

  initial begin
    nreset    = 1'b0;
    apu_wr    = 1'b0;
    cpu_rd    = 1'b0;
    reg_sel   = 3'b000;
    d_in      = 8'h00;
    t1_nt2    = 1'b0;
    div_src   = 1'b0;
    ch_active = 4'b0101;
    clear_counts();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_apu_reset", apu_reset, 1);
    check("rst_napu_reset", napu_reset, 0);
    check("rst_lvolume", lvolume, 0);
    check("rst_seq_step", seq_step, 0);
    check("rst_ce_2mhz", ce_2mhz, 0);
    check("rst_length_tick", length_tick, 0);
    check("rst_d_out", d_out, 0);
    check("rst_d_oe", d_oe, 0);
    nreset = 1'b1;
    @(negedge clk);

    // 1. Power on, volume write
    bus_write(S26, 8'h80);
    bus_write(S24, 8'h77);
    check("t1_apu_reset", apu_reset, 0);
    check("t1_napu_reset", napu_reset, 1);
    check("t1_lvolume", lvolume, 7);
    check("t1_rvolume", rvolume, 7);
    check("t1_vin_l", vin_l_ena, 0);
    check("t1_vin_r", vin_r_ena, 0);
    bus_read(S24, rdata);
    check("t1_rd_ff24", rdata, 8'h77);
    bus_read(S26, rdata);
    check("t1_rd_ff26", rdata, 8'hF5);

    // 2. Panning, then power off clears everything
    bus_write(S25, 8'hA5);
    check("t2_lmixer_on", lmixer, 4'h5);
    check("t2_rmixer_on", rmixer, 4'hA);
    bus_read(S25, rdata);
    check("t2_rd_ff25_on", rdata, 8'hA5);
    bus_write(S26, 8'h00);
    check("t2_lmixer_off", lmixer, 0);
    check("t2_rmixer_off", rmixer, 0);
    check("t2_lvolume_off", lvolume, 0);
    check("t2_apu_reset_off", apu_reset, 1);
    bus_read(S25, rdata);
    check("t2_rd_ff25_off", rdata, 8'h00);
    bus_write(S24, 8'h3C);
    bus_read(S24, rdata);
    check("t2_rd_ff24_ignored", rdata, 8'h00);
    bus_read(S26, rdata);
    check("t2_rd_ff26_off", rdata, 8'h75);

    // 3. Eight div_src edges walk the full sequence
    bus_write(S26, 8'h80);
    clear_counts();
    for (int p = 0; p < 8; p++) begin
      div_pulse();
      if (p == 2) check("t3_step_after3", seq_step, 3);
      if (p == 6) check("t3_env_before8", env_n, 0);
    end
    check("t3_length_cnt", len_n, 4);
    check("t3_sweep_cnt", sw_n, 2);
    check("t3_env_cnt", env_n, 1);
    check("t3_step_wrap", seq_step, 0);

    // 4. Fast test mode: power-on edge is cycle 0, ticks land on cycles 4, 8, 12, 16
    bus_write(S26, 8'h00);
    bus_write(S26, 8'h80);
    t1_nt2 = 1'b1;
    bus_write(S26, 8'h90);
    @(negedge clk);
    @(negedge clk);
    check("t4_c3_length", length_tick, 0);
    check("t4_c3_step", seq_step, 0);
    @(negedge clk);
    check("t4_c4_length", length_tick, 1);
    check("t4_c4_step", seq_step, 1);
    clear_counts();
    for (int k = 5; k <= 17; k++) begin
      @(negedge clk);
      if (k == 6)  div_src = 1'b1;
      if (k == 10) div_src = 1'b0;
      sample();
    end
    check("t4_fast_step", seq_step, 4);
    check("t4_fast_length", len_n, 1);
    check("t4_fast_sweep", sw_n, 1);
    t1_nt2 = 1'b0;
    bus_write(S26, 8'h90);
    check("t4_gated_step", seq_step, 4);
    repeat (12) @(negedge clk);
    check("t4_no_div_step", seq_step, 4);
    clear_counts();
    div_pulse();
    check("t4_div_step", seq_step, 5);
    check("t4_div_length", len_n, 1);
    div_pulse();
    check("t4_div_step6", seq_step, 6);

    // 5. Power-off write on the same edge the detected div_src edge would tick
    div_src = 1'b1;
    @(negedge clk);
    apu_wr  = 1'b1;
    reg_sel = S26;
    d_in    = 8'h00;
    @(negedge clk);
    apu_wr  = 1'b0;
    reg_sel = 3'b000;
    clear_counts();
    sample();
    check("t5_step_zero", seq_step, 0);
    check("t5_apu_reset", apu_reset, 1);
    repeat (3) begin
      @(negedge clk);
      sample();
    end
    div_src = 1'b0;
    check("t5_no_ticks", len_n + sw_n + env_n, 0);
    bus_write(S26, 8'h80);
    clear_counts();
    div_pulse();
    check("t5_resume_length", len_n, 1);
    check("t5_resume_sweep", sw_n, 0);
    check("t5_resume_step", seq_step, 1);

    // 6. Clock-enable spacing after power-on, cycles 0..8
    bus_write(S26, 8'h00);
    bus_write(S26, 8'h80);
    ce2_v = '0;
    ce1_v = '0;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) @(negedge clk);
      ce2_v[k] = ce_2mhz;
      ce1_v[k] = ce_1mhz;
    end
    check("t6_ce_2mhz_pattern", ce2_v, 9'h154);
    check("t6_ce_1mhz_pattern", ce1_v, 9'h110);

    // Reset mid-run dominates a simultaneous power-on write
    bus_write(S24, 8'h5A);
    check("t6_lvolume", lvolume, 2);
    check("t6_rvolume", rvolume, 5);
    check("t6_vin_l", vin_l_ena, 1);
    bus_write(S25, 8'h33);
    div_pulse();
    div_pulse();
    check("t6_step_pre_rst", seq_step, 2);
    nreset  = 1'b0;
    apu_wr  = 1'b1;
    reg_sel = S26;
    d_in    = 8'h80;
    @(negedge clk);
    apu_wr  = 1'b0;
    reg_sel = 3'b000;
    d_in    = 8'h00;
    check("t6_rst_apu_reset", apu_reset, 1);
    check("t6_rst_napu_reset", napu_reset, 0);
    check("t6_rst_lvolume", lvolume, 0);
    check("t6_rst_rvolume", rvolume, 0);
    check("t6_rst_vin_l", vin_l_ena, 0);
    check("t6_rst_lmixer", lmixer, 0);
    check("t6_rst_rmixer", rmixer, 0);
    check("t6_rst_step", seq_step, 0);
    check("t6_rst_ce", {ce_2mhz, ce_1mhz}, 0);
    check("t6_rst_ticks", {length_tick, sweep_tick, env_tick}, 0);
    nreset = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_post_rst_off", apu_reset, 1);
    bus_read(S26, rdata);
    check("t6_post_rst_ff26", rdata, 8'h75);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
